// File: rtl/gth_tx_bringup_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gth_tx_bringup_sequencer                                        |
// | Purpose  : GTH TX bring-up FSM: lock wait, reset_all pulse, done/timeout,  |
// |            datapath release, link monitoring and retry. Build option:      |
// |            GTH_TX_RETRY_LIMIT_EN enables FAULT after MAX_RETRY failures.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module gth_tx_bringup_sequencer #(
    parameter int RESET_PULSE_CYCLES   = 10,
    parameter int DONE_TIMEOUT_CYCLES  = 1250000,
    parameter int RELEASE_DELAY_CYCLES = 16,
    parameter int MAX_RETRY            = 3
) (
    input  logic       s_axi_clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       freerun_locked,
    input  logic       pixel_clk_locked,
    input  logic [2:0] gt_powergood,
    input  logic       gt_tx_done,
    output logic       gt_reset_all,
    output logic       tx_active,
    output logic       datapath_resetn,
    output logic       link_up,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [2:0] state
);

    localparam logic [2:0] c_IDLE        = 3'd0;
    localparam logic [2:0] c_WAIT_LOCK   = 3'd1;
    localparam logic [2:0] c_RESET_PULSE = 3'd2;
    localparam logic [2:0] c_WAIT_DONE   = 3'd3;
    localparam logic [2:0] c_RELEASE     = 3'd4;
    localparam logic [2:0] c_RUN         = 3'd5;
    localparam logic [2:0] c_FAULT       = 3'd6;

`ifdef GTH_TX_RETRY_LIMIT_EN
    localparam bit c_RETRY_LIMIT_EN = 1'b1;
`else
    localparam bit c_RETRY_LIMIT_EN = 1'b0;
`endif

    // One shared timer serves the pulse, timeout and release phases.
    localparam int c_MAX_A   = (RESET_PULSE_CYCLES > RELEASE_DELAY_CYCLES) ?
                               RESET_PULSE_CYCLES : RELEASE_DELAY_CYCLES;
    localparam int c_TIMER_MAX = (DONE_TIMEOUT_CYCLES > c_MAX_A) ? DONE_TIMEOUT_CYCLES : c_MAX_A;
    localparam int c_TIMER_W   = $clog2(c_TIMER_MAX + 1);

    localparam logic [c_TIMER_W-1:0] c_PULSE_LAST   = c_TIMER_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMEOUT_LAST = c_TIMER_W'(DONE_TIMEOUT_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_RELEASE_LAST = c_TIMER_W'(RELEASE_DELAY_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE    = c_TIMER_W'(1);

    logic [5:0]           r_sync1;
    logic [5:0]           r_sync2;
    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [c_TIMER_W-1:0] r_timer;
    logic [c_TIMER_W-1:0] w_timer_next;
    logic [3:0]           r_retry;
    logic [3:0]           w_retry_next;
    logic                 w_fail;
    logic                 w_freerun_s;
    logic                 w_pix_s;
    logic                 w_pg_ok_s;
    logic                 w_done_s;

    // Packed as {tx_done, powergood[2:0], pixel_lock, freerun_lock}.
    always_ff @(posedge s_axi_clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {gt_tx_done, gt_powergood, pixel_clk_locked, freerun_locked};
            r_sync2 <= r_sync1;
        end
    end

    assign w_freerun_s = r_sync2[0];
    assign w_pix_s     = r_sync2[1];
    assign w_pg_ok_s   = &r_sync2[4:2];
    assign w_done_s    = r_sync2[5];

    always_ff @(posedge s_axi_clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_timer <= '0;
            r_retry <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_retry <= w_retry_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer + c_TIMER_ONE;
        w_retry_next = r_retry;
        w_fail       = 1'b0;

        case (r_state)
            c_IDLE: begin
                w_timer_next = '0;
                w_retry_next = '0;
                if (enable) w_state_next = c_WAIT_LOCK;
            end
            c_WAIT_LOCK: begin
                w_timer_next = '0;
                if (w_freerun_s && w_pg_ok_s) w_state_next = c_RESET_PULSE;
            end
            c_RESET_PULSE: begin
                if (r_timer == c_PULSE_LAST) begin
                    w_state_next = c_WAIT_DONE;
                    w_timer_next = '0;
                end
            end
            c_WAIT_DONE: begin
                // Done is checked first so it wins against a coincident timeout.
                if (w_done_s) begin
                    w_state_next = c_RELEASE;
                    w_timer_next = '0;
                end else if (r_timer == c_TIMEOUT_LAST) begin
                    w_fail = 1'b1;
                end
            end
            c_RELEASE: begin
                if (!w_pix_s) begin
                    w_timer_next = '0;
                end else if (r_timer == c_RELEASE_LAST) begin
                    w_state_next = c_RUN;
                    w_timer_next = '0;
                    w_retry_next = '0;
                end
            end
            c_RUN: begin
                w_timer_next = '0;
                if (!w_done_s || !w_pix_s) w_fail = 1'b1;
            end
            c_FAULT: begin
                w_timer_next = '0;
            end
            default: begin
                w_state_next = c_IDLE;
                w_timer_next = '0;
            end
        endcase

        if (w_fail) begin
            w_timer_next = '0;
            w_retry_next = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;
            if (c_RETRY_LIMIT_EN && (({1'b0, r_retry} + 5'd1) == 5'(MAX_RETRY)))
                w_state_next = c_FAULT;
            else
                w_state_next = c_RESET_PULSE;
        end

        if (!enable) begin
            w_state_next = c_IDLE;
            w_timer_next = '0;
            w_retry_next = '0;
        end
    end

    assign gt_reset_all    = (r_state == c_RESET_PULSE);
    assign tx_active       = w_pix_s && ((r_state == c_WAIT_DONE) ||
                                         (r_state == c_RELEASE)   ||
                                         (r_state == c_RUN));
    assign datapath_resetn = (r_state == c_RUN);
    assign link_up         = (r_state == c_RUN);
    assign retry_count     = r_retry;
    assign state           = r_state;

`ifdef GTH_TX_RETRY_LIMIT_EN
    assign fault = (r_state == c_FAULT);
`else
    assign fault = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gth_tx_bringup_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_gth_tx_bringup_sequencer                                     |
// | Purpose  : Directed bench; dut uses default timing, dut_to a 50-clk timeout.|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_gth_tx_bringup_sequencer;

    logic       s_axi_clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       freerun_locked;
    logic       pixel_clk_locked;
    logic [2:0] gt_powergood;
    logic       gt_tx_done;

    logic       gt_reset_all, tx_active, datapath_resetn, link_up, fault;
    logic [3:0] retry_count;
    logic [2:0] state;

    logic       to_gt_reset_all, to_tx_active, to_datapath_resetn, to_link_up, to_fault;
    logic [3:0] to_retry_count;
    logic [2:0] to_state;

    int n_vec  = 0;
    int n_fail = 0;
    int pulses;
    logic prev;

    always #4 s_axi_clk = ~s_axi_clk;

    gth_tx_bringup_sequencer #(
        .RESET_PULSE_CYCLES  (10),
        .DONE_TIMEOUT_CYCLES (1250000),
        .RELEASE_DELAY_CYCLES(16),
        .MAX_RETRY           (3)
    ) dut (
        .s_axi_clk       (s_axi_clk),
        .reset           (reset),
        .enable          (enable),
        .freerun_locked  (freerun_locked),
        .pixel_clk_locked(pixel_clk_locked),
        .gt_powergood    (gt_powergood),
        .gt_tx_done      (gt_tx_done),
        .gt_reset_all    (gt_reset_all),
        .tx_active       (tx_active),
        .datapath_resetn (datapath_resetn),
        .link_up         (link_up),
        .fault           (fault),
        .retry_count     (retry_count),
        .state           (state)
    );

    gth_tx_bringup_sequencer #(
        .RESET_PULSE_CYCLES  (10),
        .DONE_TIMEOUT_CYCLES (50),
        .RELEASE_DELAY_CYCLES(16),
        .MAX_RETRY           (3)
    ) dut_to (
        .s_axi_clk       (s_axi_clk),
        .reset           (reset),
        .enable          (enable),
        .freerun_locked  (freerun_locked),
        .pixel_clk_locked(pixel_clk_locked),
        .gt_powergood    (gt_powergood),
        .gt_tx_done      (gt_tx_done),
        .gt_reset_all    (to_gt_reset_all),
        .tx_active       (to_tx_active),
        .datapath_resetn (to_datapath_resetn),
        .link_up         (to_link_up),
        .fault           (to_fault),
        .retry_count     (to_retry_count),
        .state           (to_state)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge s_axi_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset            = 1'b1;
        enable           = 1'b0;
        freerun_locked   = 1'b1;
        pixel_clk_locked = 1'b1;
        gt_powergood     = 3'b111;
        gt_tx_done       = 1'b0;
        tick(3);
        chk("rst_outputs", {gt_reset_all, tx_active, datapath_resetn, link_up, fault, retry_count, state},
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0});
        reset = 1'b0;
        tick(3);

        // Nominal bring-up; tx_done rises 100 clocks after the pulse ends.
        enable = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 112; i++) begin
            tick(1);
            if (gt_reset_all) pulses++;
            if (i == 1)  chk("nom_wait_lock", state, 3'd1);
            if (i == 2)  chk("nom_pulse_start", {tx_active, state}, {1'b0, 3'd2});
            if (i == 12) chk("nom_wait_done", state, 3'd3);
            if (i == 20) chk("nom_tx_active", tx_active, 1'b1);
            if (i == 62) chk("to_first_retry", {to_state, to_retry_count}, {3'd2, 4'd1});
        end
        chk("nom_pulse_len", pulses, 10);
        gt_tx_done = 1'b1;
        tick(3);
        chk("nom_release", state, 3'd4);
        tick(15);
        chk("nom_pre_run", {datapath_resetn, link_up, state}, {1'b0, 1'b0, 3'd4});
        tick(1);
        chk("nom_run", {datapath_resetn, link_up, state, retry_count}, {1'b1, 1'b1, 3'd5, 4'd0});

        // One-clock tx_done drop while running.
        tick(5);
        gt_tx_done = 1'b0;
        tick(1);
        gt_tx_done = 1'b1;
        tick(1);
        chk("loss_still_run", {datapath_resetn, state}, {1'b1, 3'd5});
        tick(1);
        chk("loss_detect", {datapath_resetn, link_up, state, gt_reset_all, retry_count},
            {1'b0, 1'b0, 3'd2, 1'b1, 4'd1});
        tick(11);
        chk("loss_release", {state, retry_count}, {3'd4, 4'd1});
        tick(16);
        chk("loss_rerun", {state, retry_count, link_up}, {3'd5, 4'd0, 1'b1});

        // Abort in pulse cycle 5, then a full pulse after re-enable.
        enable = 1'b0;
        tick(2);
        gt_tx_done = 1'b0;
        tick(3);
        enable = 1'b1;
        tick(6);
        chk("abort_mid_pulse", {gt_reset_all, state}, {1'b1, 3'd2});
        enable = 1'b0;
        tick(1);
        chk("abort_idle", {gt_reset_all, state, retry_count}, {1'b0, 3'd0, 4'd0});
        enable = 1'b1;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (gt_reset_all) pulses++;
        end
        chk("abort_repulse_len", pulses, 10);

        // Reset asserted mid-pulse.
        enable = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(4);
        chk("rstmid_in_pulse", gt_reset_all, 1'b1);
        reset = 1'b1;
        tick(1);
        chk("rstmid_cut", {gt_reset_all, state, tx_active}, {1'b0, 3'd0, 1'b0});
        reset  = 1'b0;
        enable = 1'b0;
        tick(3);

        // tx_done synchronised on the timeout clock of dut_to.
        enable = 1'b1;
        tick(59);
        gt_tx_done = 1'b1;
        tick(2);
        chk("simul_pre", to_state, 3'd3);
        tick(1);
        chk("simul_release", {to_state, to_retry_count}, {3'd4, 4'd0});

        // Repeated timeouts with tx_done held low.
        enable     = 1'b0;
        gt_tx_done = 1'b0;
        tick(4);
        enable = 1'b1;
        pulses = 0;
        prev   = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            tick(1);
            if (to_gt_reset_all && !prev) pulses++;
            prev = to_gt_reset_all;
        end
`ifdef GTH_TX_RETRY_LIMIT_EN
        chk("tmo_pulse_count", pulses, 3);
        chk("tmo_fault", {to_state, to_fault, to_retry_count, to_gt_reset_all},
            {3'd6, 1'b1, 4'd3, 1'b0});
`else
        chk("tmo_pulse_count", pulses, 19);
        chk("tmo_saturate", {to_fault, to_retry_count}, {1'b0, 4'd15});
        chk("tmo_no_fault_state", (to_state == 3'd6), 1'b0);
`endif
        enable = 1'b0;
        tick(1);
        chk("tmo_exit_idle", {to_state, to_fault, to_retry_count}, {3'd0, 1'b0, 4'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
